// File: rtl/rob_pkg.sv
// Shared types and default sizing for the reorder buffer / retire sequencer.
package rob_pkg;

    localparam int ROB_DEPTH_DEF     = 32;
    localparam int NUM_PHYS_REGS_DEF = 64;
    localparam int NUM_ARCH_REGS_DEF = 35;

    // Entry register fields are sized for the default register files;
    // widen these if the module is built with larger ones.
    localparam int ENT_PHYS_W = $clog2(NUM_PHYS_REGS_DEF);
    localparam int ENT_ARCH_W = $clog2(NUM_ARCH_REGS_DEF);

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  exc;
        logic                  has_dest;
        logic [ENT_ARCH_W-1:0] arch;
        logic [ENT_PHYS_W-1:0] phys;
        logic [ENT_PHYS_W-1:0] old_phys;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit circular pointer: the MSB toggles on each lap so full and empty differ.
module rob_ptr #(
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)      ptr_d = '0;
        else if (inc_i) ptr_d = ptr_q + W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_retire.sv
// Reorder buffer with in-order single-entry retire, RRAT update and free-list return.
// Optional exception flush is enabled by defining ROB_EXCEPTION_EN.
module rob_retire
    import rob_pkg::*;
#(
    parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DEF,
    parameter int NUM_ARCH_REGS = NUM_ARCH_REGS_DEF,
    parameter int ROB_DEPTH     = ROB_DEPTH_DEF,
    localparam int LOG_PHYS     = $clog2(NUM_PHYS_REGS),
    localparam int LOG_ARCH     = $clog2(NUM_ARCH_REGS),
    localparam int LOG_ROB      = $clog2(ROB_DEPTH)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Alloc_valid_IN,
    input  logic                Alloc_has_dest_IN,
    input  logic [LOG_ARCH-1:0] Alloc_arch_IN,
    input  logic [LOG_PHYS-1:0] Alloc_phys_IN,
    input  logic [LOG_PHYS-1:0] Alloc_old_phys_IN,
    output logic                Alloc_ready_OUT,
    output logic [LOG_ROB-1:0]  Alloc_tag_OUT,
    input  logic                Complete_valid_IN,
    input  logic [LOG_ROB-1:0]  Complete_tag_IN,
    input  logic                Complete_exc_IN,
    output logic [LOG_ARCH-1:0] Arch_reg_OUT,
    output logic [LOG_PHYS-1:0] Phys_reg_OUT,
    output logic                Update_OUT,
    output logic                Free_valid_OUT,
    output logic [LOG_PHYS-1:0] Free_phys_OUT,
    output logic                Flush_OUT,
    output logic [LOG_ROB:0]    Count_OUT
);

    rob_entry_t          rob_q [ROB_DEPTH];
    rob_entry_t          head_e, alloc_e;
    logic [LOG_ROB:0]    head_ptr, tail_ptr, count;
    logic [LOG_ROB-1:0]  head_idx, tail_idx;
    logic                alloc_fire, retire_fire, flush_fire, commit_fire;

    logic [LOG_ARCH-1:0] arch_q, arch_d;
    logic [LOG_PHYS-1:0] phys_q, phys_d, free_phys_q, free_phys_d;
    logic                update_q, update_d, free_valid_q, free_valid_d;

    assign head_idx        = head_ptr[LOG_ROB-1:0];
    assign tail_idx        = tail_ptr[LOG_ROB-1:0];
    assign count           = tail_ptr - head_ptr;
    assign Alloc_ready_OUT = (count != (LOG_ROB+1)'(ROB_DEPTH));
    assign Alloc_tag_OUT   = tail_idx;
    assign Count_OUT       = count;
    assign alloc_fire      = Alloc_valid_IN && Alloc_ready_OUT;

    assign head_e      = rob_q[head_idx];
    assign retire_fire = head_e.valid && head_e.done;

`ifdef ROB_EXCEPTION_EN
    logic flush_q;
    assign flush_fire = retire_fire && head_e.exc;
    always_ff @(posedge CLK) begin
        if (RESET) flush_q <= 1'b0;
        else       flush_q <= flush_fire;
    end
    assign Flush_OUT = flush_q;
`else
    logic unused_exc;
    assign unused_exc = Complete_exc_IN;
    assign flush_fire = 1'b0;
    assign Flush_OUT  = 1'b0;
`endif

    // A faulting head retires nothing architecturally; it only flushes.
    assign commit_fire = retire_fire && !flush_fire;

    rob_ptr #(.W(LOG_ROB+1)) u_head (
        .clk_i (CLK),
        .rst_i (RESET),
        .clr_i (flush_fire),
        .inc_i (commit_fire),
        .ptr_o (head_ptr)
    );

    rob_ptr #(.W(LOG_ROB+1)) u_tail (
        .clk_i (CLK),
        .rst_i (RESET),
        .clr_i (flush_fire),
        .inc_i (alloc_fire),
        .ptr_o (tail_ptr)
    );

    always_comb begin
        alloc_e          = '0;
        alloc_e.valid    = 1'b1;
        alloc_e.has_dest = Alloc_has_dest_IN;
        alloc_e.arch     = ENT_ARCH_W'(Alloc_arch_IN);
        alloc_e.phys     = ENT_PHYS_W'(Alloc_phys_IN);
        alloc_e.old_phys = ENT_PHYS_W'(Alloc_old_phys_IN);
    end

    // Completion sees pre-edge valid, so a same-edge allocation cannot be completed.
    always_ff @(posedge CLK) begin
        if (RESET || flush_fire) begin
            for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
        end else begin
            if (Complete_valid_IN && rob_q[Complete_tag_IN].valid) begin
                rob_q[Complete_tag_IN].done <= 1'b1;
`ifdef ROB_EXCEPTION_EN
                rob_q[Complete_tag_IN].exc  <= rob_q[Complete_tag_IN].exc | Complete_exc_IN;
`endif
            end
            if (commit_fire) rob_q[head_idx].valid <= 1'b0;
            if (alloc_fire)  rob_q[tail_idx]       <= alloc_e;
        end
    end

    always_comb begin
        arch_d       = arch_q;
        phys_d       = phys_q;
        free_phys_d  = free_phys_q;
        update_d     = 1'b0;
        free_valid_d = 1'b0;
        if (commit_fire) begin
            arch_d       = LOG_ARCH'(head_e.arch);
            phys_d       = LOG_PHYS'(head_e.phys);
            free_phys_d  = LOG_PHYS'(head_e.old_phys);
            update_d     = head_e.has_dest;
            free_valid_d = head_e.has_dest;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            arch_q       <= '0;
            phys_q       <= '0;
            free_phys_q  <= '0;
            update_q     <= 1'b0;
            free_valid_q <= 1'b0;
        end else begin
            arch_q       <= arch_d;
            phys_q       <= phys_d;
            free_phys_q  <= free_phys_d;
            update_q     <= update_d;
            free_valid_q <= free_valid_d;
        end
    end

    assign Arch_reg_OUT   = arch_q;
    assign Phys_reg_OUT   = phys_q;
    assign Free_phys_OUT  = free_phys_q;
    assign Update_OUT     = update_q;
    assign Free_valid_OUT = free_valid_q;

endmodule

// File: doc/rob_retire.md
# rob_retire

Reorder buffer plus in-order retire sequencer. Accepts renamed instructions from dispatch, marks them complete on writeback, and retires the oldest completed entry each cycle. Retiring an entry drives the architectural→physical update consumed by the retirement-RAT commit stage. It also returns the superseded physical register to the free list.

## Interface
- NUM_PHYS_REGS, 64, physical register count; LOG_PHYS = $clog2(NUM_PHYS_REGS)
- NUM_ARCH_REGS, 35, architectural register count; LOG_ARCH = $clog2(NUM_ARCH_REGS)
- ROB_DEPTH, 32, entry count; power of two ≥ 4; LOG_ROB = $clog2(ROB_DEPTH)

- CLK  in  1  single clock, all state on rising edge
- RESET  in  1  synchronous, active-high
- Alloc_valid_IN  in  1  dispatch offers an entry
- Alloc_has_dest_IN  in  1  entry writes a register
- Alloc_arch_IN  in  LOG_ARCH  destination architectural register
- Alloc_phys_IN  in  LOG_PHYS  newly mapped physical register
- Alloc_old_phys_IN  in  LOG_PHYS  previous mapping, freed at retire
- Alloc_ready_OUT  out  1  ROB not full
- Alloc_tag_OUT  out  LOG_ROB  index the offered entry receives (tail)
- Complete_valid_IN  in  1  writeback marks an entry done
- Complete_tag_IN  in  LOG_ROB  entry being completed
- Complete_exc_IN  in  1  entry faulted (used only with ROB_EXCEPTION_EN)
- Arch_reg_OUT  out  LOG_ARCH  retiring architectural register
- Phys_reg_OUT  out  LOG_PHYS  retiring physical register
- Update_OUT  out  1  commit stage performs the RRAT write
- Free_valid_OUT  out  1  Free_phys_OUT is returned to the free list
- Free_phys_OUT  out  LOG_PHYS  freed physical register
- Flush_OUT  out  1  pipeline flush request
- Count_OUT  out  LOG_ROB+1  occupied entries

## Operation
- Per entry: valid, done, exc, has_dest, arch, phys, old_phys. Circular buffer with head/tail pointers of LOG_ROB+1 bits. Wrap bit distinguishes full (same index, different wrap) from empty.
- Allocate: handshake is Alloc_valid_IN && Alloc_ready_OUT. Write the entry at tail with valid=1, done=0, exc=0, then increment tail. Alloc_ready_OUT = (count != ROB_DEPTH), computed from current state. A retire in the same cycle does not free a slot for allocation.
- Complete: if Complete_valid_IN and the entry at Complete_tag_IN is valid, set done. Also latch exc when the macro is enabled. Completion to an invalid entry is ignored with no state change. A repeated completion is harmless.
- Retire, at most one per cycle:
  - Condition: head entry valid && done.
  - Clear head.valid and increment head.
  - Register Arch_reg_OUT and Phys_reg_OUT from the entry.
  - Update_OUT = has_dest; Free_valid_OUT = has_dest; Free_phys_OUT = old_phys.
- When nothing retires: Update_OUT = 0 and Free_valid_OUT = 0. Data outputs hold their previous values.
- Simultaneous allocate and retire: both proceed; count is unchanged.
- Simultaneous complete and retire on the head tag: the retire evaluation sees the pre-edge done=0. The head retires on the next cycle.
- Count_OUT = tail − head, modulo 2^(LOG_ROB+1).

## Timing
- Reset state: head = tail = 0, all valid = 0, Count_OUT = 0, Alloc_ready_OUT = 1, Alloc_tag_OUT = 0. All retire outputs, Flush_OUT and the free outputs are 0.
- RESET asserted mid-operation discards all entries at that edge. Inputs sampled on the reset edge are ignored.
- Completion sampled at edge E → Update_OUT high from E+1 to E+2, when that entry is the head.
- Allocation to Update_OUT: minimum 2 edges, since completion is required in between.
- Sustained throughput: 1 retire/cycle when entries are completed in order ahead of time.

## Configuration
- ROB_EXCEPTION_EN defined:
  - A done head entry with exc=1 does not update: Update_OUT = 0 and Free_valid_OUT = 0.
  - It pulses Flush_OUT = 1 for one cycle (registered, same timing as Update_OUT).
  - On that edge, all entries are cleared: head = tail = 0, count = 0.
  - Allocation in the flush edge is dropped.
- ROB_EXCEPTION_EN undefined: exc is not stored, Complete_exc_IN is ignored, and Flush_OUT is tied 0.

## Structure
- Shared package rob_pkg: the rob_entry_t struct (valid, done, exc, has_dest, arch, phys, old_phys) and default depth/width constants. Phys/arch widths stay parameter-derived in the module.
- One natural sub-module: rob_ptr, a wrap-bit pointer counter with increment, reset and clear. It is instantiated for head and tail.

## Test plan
- Reset, then allocate arch 3 / phys 40 / old 7 and complete tag 0 → one cycle later Update_OUT=1, Arch_reg_OUT=3, Phys_reg_OUT=40, Free_phys_OUT=7.
- Allocate tags 0,1,2, then complete in order 2,1,0 → retires occur strictly in order 0,1,2, on consecutive cycles after tag 0 completes.
- Fill 32 entries → Alloc_ready_OUT=0, Count_OUT=32. An extra Alloc_valid_IN is ignored. Retire one → Alloc_ready_OUT=1 next cycle.
- Allocate 40 with retires interleaved so pointers wrap → tags wrap 31→0, and no spurious full/empty.
- Entry with Alloc_has_dest_IN=0 → it retires with Update_OUT=0 and Free_valid_OUT=0, and the head advances.
- With ROB_EXCEPTION_EN: complete tag 1 with exc=1 while tags 0–4 are allocated → tag 0 updates, then Flush_OUT pulses once, Count_OUT=0, and tags 2–4 are never retired.
